cam_read_register_table: RTL and testbench

Readback counterpart to the camera write path: decodes read-request instructions from the instruction buffer and drives the camera I2C interface with a sequence of sensor register addresses. Each addressed register is read back as two bytes, assembled into a 16-bit word, and emitted one register at a time to the telemetry side. It sits between the instruction buffer and the camera I2C interface, in parallel with the write register table.

---
 rtl/cam_reg_pkg.sv | 41 ++++
 rtl/cam_read_sequence_rom.sv | 44 ++++
 rtl/cam_read_register_table.sv | 191 +++++++++++++++++++
 tb/tb_cam_read_register_table.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_reg_pkg.sv
// rtl/cam_reg_pkg.sv - shared constants and types for the camera register readback path
package cam_reg_pkg;

  localparam logic [7:0] INSTR_SHUTTER_CAM0 = 8'h0C;
  localparam logic [7:0] INSTR_SHUTTER_CAM1 = 8'h0D;
  localparam logic [7:0] INSTR_WINDOW_CAM0  = 8'h0E;
  localparam logic [7:0] INSTR_WINDOW_CAM1  = 8'h0F;
  localparam logic [7:0] INSTR_SINGLE_READ  = 8'h10;

  localparam logic [7:0] SENS_REG_01 = 8'h01;
  localparam logic [7:0] SENS_REG_02 = 8'h02;
  localparam logic [7:0] SENS_REG_03 = 8'h03;
  localparam logic [7:0] SENS_REG_04 = 8'h04;
  localparam logic [7:0] SENS_REG_05 = 8'h05;
  localparam logic [7:0] SENS_REG_06 = 8'h06;
  localparam logic [7:0] SENS_REG_08 = 8'h08;
  localparam logic [7:0] SENS_REG_09 = 8'h09;
  localparam logic [7:0] SENS_REG_0C = 8'h0C;
  localparam logic [7:0] SENS_REG_22 = 8'h22;
  localparam logic [7:0] SENS_REG_23 = 8'h23;

  localparam int unsigned SHUTTER_LEN = 7;
  localparam int unsigned WINDOW_LEN  = 4;
  localparam int unsigned SINGLE_LEN  = 1;
  localparam int unsigned IDX_W       = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RD_HI,
    ST_RD_LO,
    ST_EMIT
  } rd_state_e;

  typedef enum logic [1:0] {
    GRP_SHUTTER,
    GRP_WINDOW,
    GRP_SINGLE
  } rd_group_e;

endpackage

// File: rtl/cam_read_sequence_rom.sv
// rtl/cam_read_sequence_rom.sv - maps (group, index) to a sensor register address and last flag
module cam_read_sequence_rom
  import cam_reg_pkg::*;
(
  input  rd_group_e        group,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       single_addr,
  output logic [7:0]       sensor_addr,
  output logic             last
);

  always_comb begin
    sensor_addr = 8'h00;
    last        = 1'b0;
    case (group)
      GRP_SHUTTER: begin
        case (idx)
          3'd0:    sensor_addr = SENS_REG_08;
          3'd1:    sensor_addr = SENS_REG_09;
          3'd2:    sensor_addr = SENS_REG_0C;
          3'd3:    sensor_addr = SENS_REG_22;
          3'd4:    sensor_addr = SENS_REG_23;
          3'd5:    sensor_addr = SENS_REG_05;
          default: sensor_addr = SENS_REG_06;
        endcase
        last = (idx >= IDX_W'(SHUTTER_LEN - 1));
      end
      GRP_WINDOW: begin
        case (idx)
          3'd0:    sensor_addr = SENS_REG_01;
          3'd1:    sensor_addr = SENS_REG_02;
          3'd2:    sensor_addr = SENS_REG_03;
          default: sensor_addr = SENS_REG_04;
        endcase
        last = (idx >= IDX_W'(WINDOW_LEN - 1));
      end
      default: begin
        sensor_addr = single_addr;
        last        = (idx >= IDX_W'(SINGLE_LEN - 1));
      end
    endcase
  end

endmodule

// File: rtl/cam_read_register_table.sv
// rtl/cam_read_register_table.sv - sequences sensor register reads over I2C and emits 16-bit words
// Optional read-back timeout abort enabled by defining CAM_RD_TIMEOUT_EN.
module cam_read_register_table
  import cam_reg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        sysClk,
  input  logic        reset,
  input  logic [7:0]  reg_addr,
  input  logic [63:0] reg_data,
  input  logic        intr_valid_input,
  input  logic        ready_for_next_byte,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_valid,
  output logic [7:0]  cam_i2c_byte_out,
  output logic        cam_i2c_output_valid,
  output logic        cam_i2c_rd_req,
  output logic        cam_id,
  output logic [7:0]  rb_sensor_addr,
  output logic [15:0] rb_data,
  output logic        rb_valid,
  output logic        done,
  output logic        error,
  output logic        busy
);

  rd_state_e        state_q, state_d;
  rd_group_e        group_q, group_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cam_id_q, cam_id_d;
  logic [7:0]       single_addr_q, single_addr_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       rb_sensor_addr_q, rb_sensor_addr_d;
  logic [15:0]      rb_data_q, rb_data_d;
  logic             rb_valid_q, rb_valid_d;
  logic             done_q, done_d;
  logic             intr_q, intr_d;
  logic             trigger;
  logic [7:0]       seq_addr;
  logic             seq_last;
  logic             unused_reg_data;

  assign unused_reg_data = ^reg_data[63:9];

`ifdef CAM_RD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             error_q, error_d;
  assign error = error_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign error = 1'b0;
`endif

  cam_read_sequence_rom u_rom (
    .group       (group_q),
    .idx         (idx_q),
    .single_addr (single_addr_q),
    .sensor_addr (seq_addr),
    .last        (seq_last)
  );

  assign trigger = intr_valid_input & ~intr_q;

  always_comb begin
    state_d          = state_q;
    group_d          = group_q;
    idx_d            = idx_q;
    cam_id_d         = cam_id_q;
    single_addr_d    = single_addr_q;
    hi_d             = hi_q;
    rb_sensor_addr_d = rb_sensor_addr_q;
    rb_data_d        = rb_data_q;
    rb_valid_d       = 1'b0;
    done_d           = 1'b0;
    intr_d           = intr_valid_input;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          idx_d = '0;
          case (reg_addr)
            INSTR_SHUTTER_CAM0, INSTR_SHUTTER_CAM1: begin
              group_d  = GRP_SHUTTER;
              cam_id_d = reg_addr[0];
              state_d  = ST_ADDR;
            end
            INSTR_WINDOW_CAM0, INSTR_WINDOW_CAM1: begin
              group_d  = GRP_WINDOW;
              cam_id_d = reg_addr[0];
              state_d  = ST_ADDR;
            end
            INSTR_SINGLE_READ: begin
              group_d       = GRP_SINGLE;
              single_addr_d = reg_data[7:0];
              cam_id_d      = reg_data[8];
              state_d       = ST_ADDR;
            end
            default: ;
          endcase
        end
      end
      ST_ADDR: if (ready_for_next_byte) state_d = ST_RD_HI;
      ST_RD_HI: begin
        if (rx_byte_valid) begin
          hi_d    = rx_byte;
          state_d = ST_RD_LO;
        end
      end
      ST_RD_LO: begin
        // Word outputs are registered here so they appear exactly while in EMIT.
        if (rx_byte_valid) begin
          rb_valid_d       = 1'b1;
          rb_data_d        = {hi_q, rx_byte};
          rb_sensor_addr_d = seq_addr;
          done_d           = seq_last;
          state_d          = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (seq_last) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_ADDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef CAM_RD_TIMEOUT_EN
    error_d  = 1'b0;
    to_cnt_d = '0;
    if ((state_q == ST_RD_HI || state_q == ST_RD_LO) && state_d == state_q) begin
      if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        error_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge sysClk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      group_q          <= GRP_SHUTTER;
      idx_q            <= '0;
      cam_id_q         <= 1'b0;
      single_addr_q    <= 8'h00;
      hi_q             <= 8'h00;
      rb_sensor_addr_q <= 8'h00;
      rb_data_q        <= 16'h0000;
      rb_valid_q       <= 1'b0;
      done_q           <= 1'b0;
      intr_q           <= 1'b0;
`ifdef CAM_RD_TIMEOUT_EN
      to_cnt_q         <= '0;
      error_q          <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      group_q          <= group_d;
      idx_q            <= idx_d;
      cam_id_q         <= cam_id_d;
      single_addr_q    <= single_addr_d;
      hi_q             <= hi_d;
      rb_sensor_addr_q <= rb_sensor_addr_d;
      rb_data_q        <= rb_data_d;
      rb_valid_q       <= rb_valid_d;
      done_q           <= done_d;
      intr_q           <= intr_d;
`ifdef CAM_RD_TIMEOUT_EN
      to_cnt_q         <= to_cnt_d;
      error_q          <= error_d;
`endif
    end
  end

  assign cam_i2c_output_valid = (state_q == ST_ADDR);
  assign cam_i2c_byte_out     = (state_q == ST_ADDR) ? seq_addr : 8'h00;
  assign cam_i2c_rd_req       = (state_q == ST_ADDR) || (state_q == ST_RD_HI) || (state_q == ST_RD_LO);
  assign busy                 = (state_q != ST_IDLE);
  assign cam_id               = cam_id_q;
  assign rb_sensor_addr       = rb_sensor_addr_q;
  assign rb_data              = rb_data_q;
  assign rb_valid             = rb_valid_q;
  assign done                 = done_q;

endmodule

// File: tb/tb_cam_read_register_table.sv
// tb/tb_cam_read_register_table.sv - directed self-checking bench for cam_read_register_table
module tb_cam_read_register_table;

  logic        sysClk = 1'b0;
  logic        reset;
  logic [7:0]  reg_addr;
  logic [63:0] reg_data;
  logic        intr_valid_input;
  logic        ready_for_next_byte;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic [7:0]  cam_i2c_byte_out;
  logic        cam_i2c_output_valid;
  logic        cam_i2c_rd_req;
  logic        cam_id;
  logic [7:0]  rb_sensor_addr;
  logic [15:0] rb_data;
  logic        rb_valid;
  logic        done;
  logic        error;
  logic        busy;

  always #5 sysClk = ~sysClk;

  cam_read_register_table #(.TIMEOUT_CYCLES(16)) dut (
    .sysClk               (sysClk),
    .reset                (reset),
    .reg_addr             (reg_addr),
    .reg_data             (reg_data),
    .intr_valid_input     (intr_valid_input),
    .ready_for_next_byte  (ready_for_next_byte),
    .rx_byte              (rx_byte),
    .rx_byte_valid        (rx_byte_valid),
    .cam_i2c_byte_out     (cam_i2c_byte_out),
    .cam_i2c_output_valid (cam_i2c_output_valid),
    .cam_i2c_rd_req       (cam_i2c_rd_req),
    .cam_id               (cam_id),
    .rb_sensor_addr       (rb_sensor_addr),
    .rb_data              (rb_data),
    .rb_valid             (rb_valid),
    .done                 (done),
    .error                (error),
    .busy                 (busy)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        last;
  } word_t;

  int    n_checks = 0;
  int    n_errors = 0;
  int    rb_cnt = 0;
  int    done_cnt = 0;
  bit    allow_abort = 1'b0;
  word_t exp_q[$];
  word_t cur;
  logic [7:0] shutter_tbl [7] = '{8'h08, 8'h09, 8'h0C, 8'h22, 8'h23, 8'h05, 8'h06};
  logic [7:0] window_tbl  [4] = '{8'h01, 8'h02, 8'h03, 8'h04};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  // Reference: which sensor registers an instruction reads, and for which camera.
  task automatic model_seq(input logic [7:0] ra, input logic [63:0] rd,
                           output logic [7:0] addrs[$], output logic cam);
    addrs = {};
    cam   = ra[0];
    if (ra == 8'h0C || ra == 8'h0D) begin
      foreach (shutter_tbl[i]) addrs.push_back(shutter_tbl[i]);
    end else if (ra == 8'h0E || ra == 8'h0F) begin
      foreach (window_tbl[i]) addrs.push_back(window_tbl[i]);
    end else if (ra == 8'h10) begin
      addrs.push_back(rd[7:0]);
      cam = rd[8];
    end
  endtask

  always @(negedge sysClk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (rb_valid) begin
        rb_cnt++;
        chk("error_with_word", error, 1'b0);
        if (exp_q.size() == 0) begin
          chk("rb_unexpected", rb_valid, 1'b0);
        end else begin
          cur = exp_q.pop_front();
          chk("rb_sensor_addr", rb_sensor_addr, cur.addr);
          chk("rb_data", rb_data, cur.data);
          chk("done_on_last", done, cur.last);
        end
      end else if (!allow_abort) begin
        chk("stray_done", done, 1'b0);
        chk("stray_error", error, 1'b0);
      end
      chk("rd_req_state", cam_i2c_rd_req, busy & ~rb_valid);
      if (cam_i2c_output_valid) chk("valid_implies_rd_req", cam_i2c_rd_req, 1'b1);
    end
  end

  task automatic trigger(input logic [7:0] ra, input logic [63:0] rd);
    reg_addr = ra;
    reg_data = rd;
    intr_valid_input = 1'b1;
    tick();
    intr_valid_input = 1'b0;
  endtask

  task automatic serve(input logic [7:0] exp_addr, input logic exp_cam,
                       input logic [7:0] hi, input logic [7:0] lo, input int aw, input int gap);
    int n = 0;
    while (!cam_i2c_output_valid && n < 20) begin
      tick();
      n++;
    end
    chk("addr_valid", cam_i2c_output_valid, 1'b1);
    chk("byte_out", cam_i2c_byte_out, exp_addr);
    chk("cam_id", cam_id, exp_cam);
    for (int i = 0; i < aw; i++) begin
      rx_byte_valid = 1'b1;
      rx_byte = 8'hEE;
      tick();
      chk("byte_stable", cam_i2c_byte_out, exp_addr);
      chk("valid_held", cam_i2c_output_valid, 1'b1);
    end
    rx_byte_valid = 1'b0;
    ready_for_next_byte = 1'b1;
    tick();
    ready_for_next_byte = 1'b0;
    chk("valid_drops", cam_i2c_output_valid, 1'b0);
    rx_byte = hi;
    rx_byte_valid = 1'b1;
    tick();
    if (gap > 0) begin
      rx_byte_valid = 1'b0;
      ready_for_next_byte = 1'b1;
      repeat (gap) begin
        tick();
        chk("wait_lo_rd_req", cam_i2c_rd_req, 1'b1);
        chk("wait_lo_no_word", rb_valid, 1'b0);
      end
      ready_for_next_byte = 1'b0;
      rx_byte_valid = 1'b1;
    end
    rx_byte = lo;
    tick();
    rx_byte_valid = 1'b0;
  endtask

  task automatic run_seq(input logic [7:0] ra, input logic [63:0] rd, input logic [7:0] hib,
                         input logic [7:0] lob, input int aw, input int gap, input int retrig_at);
    logic [7:0] addrs[$];
    logic       cam;
    model_seq(ra, rd, addrs, cam);
    trigger(ra, rd);
    chk("start_latency", cam_i2c_output_valid, 1'b1);
    for (int i = 0; i < addrs.size(); i++) begin
      word_t w;
      w.addr = addrs[i];
      w.data = {hib + 8'(i), lob + 8'(i)};
      w.last = (i == addrs.size() - 1);
      exp_q.push_back(w);
      serve(addrs[i], cam, hib + 8'(i), lob + 8'(i), aw, gap);
      if (i == retrig_at) begin
        reg_addr = 8'h0C;
        intr_valid_input = 1'b1;
        tick();
        intr_valid_input = 1'b0;
      end
    end
  endtask

  task automatic finish_seq(input int done_start, input int rb_start, input int exp_words);
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    chk("done_count", done_cnt - done_start, 1);
    chk("word_count", rb_cnt - rb_start, exp_words);
    chk("idle_after", busy, 1'b0);
  endtask

  task automatic chk_all_zero();
    chk("z_byte_out", cam_i2c_byte_out, 8'h00);
    chk("z_out_valid", cam_i2c_output_valid, 1'b0);
    chk("z_rd_req", cam_i2c_rd_req, 1'b0);
    chk("z_cam_id", cam_id, 1'b0);
    chk("z_rb_addr", rb_sensor_addr, 8'h00);
    chk("z_rb_data", rb_data, 16'h0000);
    chk("z_rb_valid", rb_valid, 1'b0);
    chk("z_done", done, 1'b0);
    chk("z_error", error, 1'b0);
    chk("z_busy", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ds, rs;
    reset = 1'b1;
    reg_addr = 8'h00;
    reg_data = 64'h0;
    intr_valid_input = 1'b0;
    ready_for_next_byte = 1'b0;
    rx_byte = 8'h00;
    rx_byte_valid = 1'b0;
    repeat (3) tick();
    chk_all_zero();
    reset = 1'b0;
    tick();

    // Single read: reg_data=0x108 -> camera 1, register 0x08, word 0x012C
    ds = done_cnt; rs = rb_cnt;
    run_seq(8'h10, 64'h108, 8'h01, 8'h2C, 0, 0, -1);
    chk("single_rb_valid", rb_valid, 1'b1);
    chk("single_rb_data", rb_data, 16'h012C);
    chk("single_rb_addr", rb_sensor_addr, 8'h08);
    chk("single_done", done, 1'b1);
    chk("single_cam_id", cam_id, 1'b1);
    tick();
    chk("single_busy_after", busy, 1'b0);
    chk("single_pulse_width", rb_valid, 1'b0);
    chk("single_data_hold", rb_data, 16'h012C);
    finish_seq(ds, rs, 1);

    // Window group on camera 0 with handshake stalls and a gap before the lo byte
    ds = done_cnt; rs = rb_cnt;
    run_seq(8'h0E, 64'h0, 8'h00, 8'hA0, 2, 1, -1);
    chk("window_last_data", rb_data, 16'h03A3);
    chk("window_last_addr", rb_sensor_addr, 8'h04);
    chk("window_cam_id", cam_id, 1'b0);
    finish_seq(ds, rs, 4);

    // Shutter group on camera 1
    ds = done_cnt; rs = rb_cnt;
    run_seq(8'h0D, 64'h0, 8'h40, 8'h10, 1, 0, -1);
    chk("shutter_last_data", rb_data, 16'h4616);
    chk("shutter_last_addr", rb_sensor_addr, 8'h06);
    finish_seq(ds, rs, 7);

    // Retrigger with 0x0C mid-sequence of 0x0F must be ignored
    ds = done_cnt; rs = rb_cnt;
    run_seq(8'h0F, 64'h0, 8'h11, 8'h22, 0, 0, 0);
    chk("retrig_cam_id", cam_id, 1'b1);
    finish_seq(ds, rs, 4);

    // Unknown instruction address does nothing
    rs = rb_cnt;
    trigger(8'h03, 64'h1FF);
    repeat (5) begin
      chk("unknown_busy", busy, 1'b0);
      chk("unknown_valid", cam_i2c_output_valid, 1'b0);
      tick();
    end
    chk("unknown_no_word", rb_cnt - rs, 0);

    // Stray rx and ready while idle
    rx_byte_valid = 1'b1;
    ready_for_next_byte = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_byte = 8'h30 + 8'(i);
      tick();
      chk("stray_rx_busy", busy, 1'b0);
    end
    rx_byte_valid = 1'b0;
    ready_for_next_byte = 1'b0;
    tick();
    chk("stray_rx_no_word", rb_cnt - rs, 0);

    // Byte accepted, sensor never answers
    trigger(8'h10, 64'h011);
    chk("to_start", cam_i2c_output_valid, 1'b1);
    ready_for_next_byte = 1'b1;
    tick();
    ready_for_next_byte = 1'b0;
    allow_abort = 1'b1;
    rs = rb_cnt;
`ifdef CAM_RD_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("to_done", done, (k == 16) ? 1'b1 : 1'b0);
      chk("to_error", error, (k == 16) ? 1'b1 : 1'b0);
    end
    chk("to_no_word", rb_cnt - rs, 0);
    tick();
    chk("to_idle", busy, 1'b0);
    chk("to_done_pulse", done, 1'b0);
    allow_abort = 1'b0;
`else
    allow_abort = 1'b0;
    repeat (40) tick();
    chk("wait_busy", busy, 1'b1);
    chk("wait_rd_req", cam_i2c_rd_req, 1'b1);
    chk("wait_no_word", rb_cnt - rs, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("wait_reset_idle", busy, 1'b0);
`endif

    // Reset while waiting for the lo byte aborts silently
    ds = done_cnt;
    trigger(8'h10, 64'h0133);
    ready_for_next_byte = 1'b1;
    tick();
    ready_for_next_byte = 1'b0;
    rx_byte = 8'h77;
    rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
    chk("rdlo_rd_req", cam_i2c_rd_req, 1'b1);
    reset = 1'b1;
    tick();
    chk_all_zero();
    reset = 1'b0;
    tick();
    chk("reset_no_done", done_cnt - ds, 0);

    ds = done_cnt; rs = rb_cnt;
    run_seq(8'h10, 64'h0155, 8'hBE, 8'hEF, 0, 0, -1);
    chk("post_reset_data", rb_data, 16'hBEEF);
    chk("post_reset_addr", rb_sensor_addr, 8'h55);
    chk("post_reset_cam", cam_id, 1'b1);
    finish_seq(ds, rs, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
